pss_tx_gen: RTL and testbench
=============================

PSS_TX_GEN -- requirements
Module: pss_tx_gen

Interface
REQ-001 Parameter OUT_DW, 32: output sample width; imag in [OUT_DW-1:OUT_DW/2], real in [OUT_DW/2-1:0], both signed two's complement.
REQ-002 Parameter FFT_LEN, 256: frame length in bins; power of two, >= 128.
REQ-003 Parameter AMP, 2**(OUT_DW/2-2): BPSK magnitude written to the real part.
REQ-004 clk_i  in  1  single clock; all logic on posedge.
REQ-005 reset_ni  in  1  asynchronous, active-low reset.
REQ-006 s_axis_cfg_tdata  in  2  N_id_2 request.
REQ-007 s_axis_cfg_tvalid / s_axis_cfg_tready  in / out  1 each  AXI-stream config handshake.
REQ-008 m_axis_out_tdata  out  OUT_DW  frequency-domain IQ sample, natural IFFT bin order.
REQ-009 m_axis_out_tvalid / m_axis_out_tready  out / in  1 each  AXI-stream output handshake.
REQ-010 m_axis_out_tlast  out  1  high on bin FFT_LEN-1.
REQ-011 m_axis_out_tuser  out  1  high on bin 0 (frame start).
REQ-012 cfg_err_o  out  1  one-cycle pulse when an invalid N_id_2 is accepted.

Function
REQ-013 The block SHALL use states IDLE and RUN; s_axis_cfg_tready SHALL equal 1 only in IDLE.
- IDLE -> RUN on a cfg handshake with N_id_2 in 0..2.
- RUN -> IDLE when the bin FFT_LEN-1 beat is accepted.
REQ-014 A cfg handshake with N_id_2 = 3 SHALL pulse cfg_err_o on the next cycle, stay in IDLE and emit no beat.
REQ-015 The first beat (bin 0) SHALL assert tvalid on the cycle after the cfg handshake.
REQ-016 One frame SHALL be exactly FFT_LEN beats, bins 0..FFT_LEN-1, with no gaps while tready=1.
REQ-017 Subcarrier mapping SHALL be: PSS index n (0..126) goes to bin (n-63) mod FFT_LEN.
- bins 0..63 carry n=63..126.
- bins FFT_LEN-63..FFT_LEN-1 carry n=0..62.
- all other bins are 0.
REQ-018 Sequence SHALL be d(n) = 1-2*x(m), with m = (n + 43*N_id_2) mod 127.
- x(i+7) = x(i+4) XOR x(i).
- x(0..6) = 0,1,1,0,1,1,1.
REQ-019 d = +1 SHALL give real = +AMP; d = -1 SHALL give real = -AMP; imag SHALL always be 0.
REQ-020 Index m SHALL be kept in a 7-bit counter that wraps 126 -> 0; no divider or modulo operator.
REQ-021 While tvalid=1 and tready=0, tdata, tlast, tuser and the bin counter SHALL hold.
REQ-022 tvalid SHALL NOT drop mid-frame except under reset.
REQ-023 N_id_2 SHALL be latched at the cfg handshake; s_axis_cfg_tdata changes during RUN SHALL have no effect.
REQ-024 A new frame SHALL only start after a fresh cfg handshake in IDLE; back-to-back frames SHALL be separated by at least one IDLE cycle.

Reset
REQ-025 Asserting reset_ni low SHALL immediately force, regardless of the clock:
- state to IDLE.
- m_axis_out_tvalid, tdata, tlast, tuser and cfg_err_o to 0.
- bin counter and m counter to 0.
- s_axis_cfg_tready to 0.
REQ-026 After reset is released, s_axis_cfg_tready SHALL go to 1 on the first clock edge.
REQ-027 Reset during RUN SHALL abandon the frame; no partial frame SHALL resume afterwards.

Structure
REQ-028 A shared package SHALL hold:
- the 127-bit x(m) table constant.
- PSS_LEN = 127.
- the per-N_id_2 shift constant 43.
- the state enum type.
REQ-029 One sub-module, pss_seq_rom, SHALL map a 7-bit m to a 1-bit x(m) combinationally; all other logic lives in pss_tx_gen.

Verification
REQ-030 Nominal frame: N_id_2 = 0, tready held 1 -> exactly 256 beats with tuser at beat 0 and tlast at beat 255.
- bin 193 real = +AMP, bin 194 real = -AMP.
- bins 64..192 all zero; imag = 0 everywhere.
REQ-031 All N_id_2 values: frames for N_id_2 = 1 and 2 -> each bin matches a bit-exact reference model.
- for N_id_2 = 1, bin 193 uses m = 43.
REQ-032 Backpressure: tready driven with a random 50% pattern -> the accepted beat sequence is identical to REQ-030; tdata stays stable while stalled.
REQ-033 Invalid config: N_id_2 = 3 -> cfg_err_o is high for exactly 1 cycle and tvalid stays 0; a following N_id_2 = 0 request produces a correct frame.
REQ-034 Reset mid-frame: reset_ni pulsed low at beat 100 -> tvalid is 0 asynchronously.
- cfg_tready returns to 1 after release.
- the next request produces a full 256-beat frame starting at bin 0.

Source files
------------

// File: rtl/pss_tx_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pss_tx_gen_pkg
//  Description : Shared constants, types and helpers for the PSS generator:
//                m-sequence table, sequence length, N_id_2 shift and FSM
//                state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package pss_tx_gen_pkg;

    localparam int PSS_LEN   = 127;
    localparam int NID_SHIFT = 43;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // x(i+7) = x(i+4) ^ x(i), seeded with x(0..6) = 0,1,1,0,1,1,1.
    // Evaluated at elaboration only, so the result is a plain constant.
    function automatic logic [PSS_LEN-1:0] gen_x_table();
        logic [PSS_LEN-1:0] t;
        t = '0;
        t[6:0] = 7'b1110110;
        for (int i = 0; i < PSS_LEN - 7; i++) begin
            t[i+7] = t[i+4] ^ t[i];
        end
        return t;
    endfunction

    localparam logic [PSS_LEN-1:0] PSS_X_TABLE = gen_x_table();

    // Starting m for bin 0 (n = 63): (63 + 43*N_id_2) mod 127, unrolled so
    // no modulo hardware is needed. Invalid N_id_2 never starts a frame.
    function automatic logic [6:0] m_start(input logic [1:0] nid);
        case (nid)
            2'd0:    return 7'(63);
            2'd1:    return 7'(63 + NID_SHIFT);
            2'd2:    return 7'(63 + 2*NID_SHIFT - PSS_LEN);
            default: return 7'd0;
        endcase
    endfunction

    // Seven-bit counter step that wraps 126 -> 0.
    function automatic logic [6:0] m_inc(input logic [6:0] m);
        return (m == 7'(PSS_LEN - 1)) ? 7'd0 : m + 7'd1;
    endfunction

endpackage : pss_tx_gen_pkg
`default_nettype wire

// File: rtl/pss_tx_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pss_tx_gen_if
//  Description : Config and output AXI-stream bundle of the PSS generator.
//                slave  = generator side, master = upstream/downstream side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pss_tx_gen_if #(
    parameter int OUT_DW = 32
) ();
    logic [1:0]        s_axis_cfg_tdata;
    logic              s_axis_cfg_tvalid;
    logic              s_axis_cfg_tready;
    logic [OUT_DW-1:0] m_axis_out_tdata;
    logic              m_axis_out_tvalid;
    logic              m_axis_out_tready;
    logic              m_axis_out_tlast;
    logic              m_axis_out_tuser;

    modport slave (
        input  s_axis_cfg_tdata,
        input  s_axis_cfg_tvalid,
        output s_axis_cfg_tready,
        output m_axis_out_tdata,
        output m_axis_out_tvalid,
        input  m_axis_out_tready,
        output m_axis_out_tlast,
        output m_axis_out_tuser
    );

    modport master (
        output s_axis_cfg_tdata,
        output s_axis_cfg_tvalid,
        input  s_axis_cfg_tready,
        input  m_axis_out_tdata,
        input  m_axis_out_tvalid,
        output m_axis_out_tready,
        input  m_axis_out_tlast,
        input  m_axis_out_tuser
    );
endinterface : pss_tx_gen_if
`default_nettype wire

// File: rtl/pss_seq_rom.sv
`default_nettype none
// ============================================================================
//  Module      : pss_seq_rom
//  Description : Combinational lookup of the PSS m-sequence bit x(m).
//  Revision    : 1.0 - initial release
// ============================================================================
module pss_seq_rom
    import pss_tx_gen_pkg::*;
(
    input  wire logic [6:0] i_m,
    output logic            o_x
);
    // m never reaches 127 because the index counter wraps at 126.
    assign o_x = PSS_X_TABLE[i_m];
endmodule : pss_seq_rom
`default_nettype wire

// File: rtl/pss_tx_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pss_tx_gen
//  Description : Emits one frequency-domain PSS frame (BPSK on the real
//                rail, natural IFFT bin order) per accepted N_id_2 request.
//  Revision    : 1.0 - initial release
// ============================================================================
module pss_tx_gen
    import pss_tx_gen_pkg::*;
#(
    parameter int OUT_DW  = 32,
    parameter int FFT_LEN = 256,
    parameter int AMP     = 2**(OUT_DW/2-2)
) (
    input  wire logic    clk_i,
    input  wire logic    reset_ni,
    pss_tx_gen_if.slave  bus,
    output logic         cfg_err_o
);
    localparam int                    c_HW         = OUT_DW / 2;
    localparam int                    c_BW         = $clog2(FFT_LEN);
    localparam logic [c_BW-1:0]       c_LAST_BIN   = c_BW'(FFT_LEN - 1);
    localparam logic [c_BW-1:0]       c_LOW_LAST   = c_BW'(63);
    localparam logic [c_BW-1:0]       c_HIGH_FIRST = c_BW'(FFT_LEN - 63);
    localparam logic signed [c_HW-1:0] c_POS       = c_HW'(AMP);
    localparam logic signed [c_HW-1:0] c_NEG       = -c_POS;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_cfg_ready;
    logic                r_cfg_err;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_tuser;
    logic [OUT_DW-1:0]   r_tdata;
    logic [c_BW-1:0]     r_bin;
    logic [6:0]          r_m;

    logic                w_cfg_hs;
    logic                w_nid_ok;
    logic                w_out_hs;
    logic [c_BW-1:0]     w_next_bin;
    logic                w_next_active;
    logic [6:0]          w_m_start;
    logic [6:0]          w_rom_addr;
    logic                w_rom_bit;
    logic [OUT_DW-1:0]   w_sample;

    // cfg_tready is only high in IDLE, so the two handshakes are exclusive.
    assign w_cfg_hs      = r_cfg_ready && bus.s_axis_cfg_tvalid;
    assign w_nid_ok      = (bus.s_axis_cfg_tdata != 2'd3);
    assign w_out_hs      = r_tvalid && bus.m_axis_out_tready;
    assign w_next_bin    = r_bin + c_BW'(1);
    assign w_next_active = (w_next_bin <= c_LOW_LAST) || (w_next_bin >= c_HIGH_FIRST);
    // N_id_2 is captured only through the starting m value; after that the
    // m counter carries the sequence offset and cfg_tdata is ignored.
    assign w_m_start     = m_start(bus.s_axis_cfg_tdata);
    // After n = 126 the counter naturally lands on m for n = 0, so it just
    // holds through the zero bins in the middle of the frame.
    assign w_rom_addr    = r_cfg_ready ? w_m_start : r_m;
    assign w_sample      = {{c_HW{1'b0}}, (w_rom_bit ? c_NEG : c_POS)};

    pss_seq_rom u_rom (
        .i_m (w_rom_addr),
        .o_x (w_rom_bit)
    );

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_state <= ST_IDLE;
        else           r_state <= w_next_state;
    end

    // Next-state decode: start on a valid request, stop on the last beat
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_cfg_hs && w_nid_ok)     w_next_state = ST_RUN;
            ST_RUN:  if (w_out_hs && r_tlast)      w_next_state = ST_IDLE;
            default:                               w_next_state = ST_IDLE;
        endcase
    end

    // Output beat, bin/m counters and config handshake registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_tdata     <= '0;
            r_bin       <= '0;
            r_m         <= '0;
        end else begin
            r_cfg_ready <= (w_next_state == ST_IDLE);
            r_cfg_err   <= w_cfg_hs && !w_nid_ok;
            if (w_cfg_hs && w_nid_ok) begin
                r_tvalid <= 1'b1;
                r_tuser  <= 1'b1;
                r_tlast  <= 1'b0;
                r_bin    <= '0;
                r_tdata  <= w_sample;
                r_m      <= m_inc(w_m_start);
            end else if (w_out_hs) begin
                if (r_tlast) begin
                    r_tvalid <= 1'b0;
                    r_tuser  <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_bin    <= '0;
                    r_tdata  <= '0;
                    r_m      <= '0;
                end else begin
                    r_bin   <= w_next_bin;
                    r_tuser <= 1'b0;
                    r_tlast <= (w_next_bin == c_LAST_BIN);
                    r_tdata <= w_next_active ? w_sample : '0;
                    if (w_next_active) r_m <= m_inc(r_m);
                end
            end
        end
    end

    assign bus.s_axis_cfg_tready = r_cfg_ready;
    assign bus.m_axis_out_tvalid = r_tvalid;
    assign bus.m_axis_out_tdata  = r_tdata;
    assign bus.m_axis_out_tlast  = r_tlast;
    assign bus.m_axis_out_tuser  = r_tuser;
    assign cfg_err_o             = r_cfg_err;

endmodule : pss_tx_gen
`default_nettype wire

// File: tb/tb_pss_tx_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pss_tx_gen
//  Description : Scoreboard bench for pss_tx_gen. Stimulus pushes expected
//                beats; a negedge monitor compares every valid beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pss_tx_gen;
    localparam int c_DW   = 32;
    localparam int c_FFT  = 256;
    localparam logic [31:0] c_PLUS  = 32'h0000_4000;
    localparam logic [31:0] c_MINUS = 32'h0000_C000;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        int          bin;
        int          nid;
    } exp_t;

    logic clk;
    logic reset_ni;
    logic cfg_err;
    int   tests;
    int   fails;
    int   accepted;
    bit   bp_en;
    bit   x_ref [127];
    exp_t q [$];

    pss_tx_gen_if #(.OUT_DW(c_DW)) bus ();

    pss_tx_gen #(.OUT_DW(c_DW), .FFT_LEN(c_FFT)) dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .bus       (bus),
        .cfg_err_o (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bin -> n -> m -> BPSK sample on the real rail
    function automatic logic [31:0] ref_data(input int nid, input int k);
        int n;
        int m;
        if (k <= 63)               n = k + 63;
        else if (k >= c_FFT - 63)  n = k - (c_FFT - 63);
        else                       return 32'h0;
        m = (n + 43 * nid) % 127;
        return x_ref[m] ? c_MINUS : c_PLUS;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid beat is compared to the queue head; pop on accept
    always @(negedge clk) begin
        if (reset_ni && bus.m_axis_out_tvalid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %h expected no beat", bus.m_axis_out_tdata);
            end else begin
                exp_t e;
                e = q[0];
                tests++;
                if (bus.m_axis_out_tdata !== e.data || bus.m_axis_out_tlast !== e.last ||
                    bus.m_axis_out_tuser !== e.user) begin
                    fails++;
                    $display("FAIL beat nid=%0d bin=%0d: got data=%h last=%b user=%b expected data=%h last=%b user=%b",
                             e.nid, e.bin, bus.m_axis_out_tdata, bus.m_axis_out_tlast,
                             bus.m_axis_out_tuser, e.data, e.last, e.user);
                end
                if (e.nid == 0 && e.bin == 193)
                    check("bin193_plus_amp", bus.m_axis_out_tdata, c_PLUS);
                if (e.nid == 0 && e.bin == 194)
                    check("bin194_minus_amp", bus.m_axis_out_tdata, c_MINUS);
                if (bus.m_axis_out_tready) begin
                    void'(q.pop_front());
                    accepted++;
                end
            end
        end
    end

    // Output backpressure: always ready, or a random 50% pattern
    always @(posedge clk) begin
        #1;
        bus.m_axis_out_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send_cfg(input logic [1:0] nid, input bit expect_frame);
        int b;
        b = 0;
        while (!bus.s_axis_cfg_tready && b < 1000) begin
            @(posedge clk); #1;
            b++;
        end
        check("cfg_ready_before_req", 32'(bus.s_axis_cfg_tready), 32'd1);
        if (expect_frame) begin
            for (int k = 0; k < c_FFT; k++) begin
                exp_t e;
                e.data = ref_data(int'(nid), k);
                e.last = (k == c_FFT - 1);
                e.user = (k == 0);
                e.bin  = k;
                e.nid  = int'(nid);
                q.push_back(e);
            end
        end
        bus.s_axis_cfg_tdata  = nid;
        bus.s_axis_cfg_tvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axis_cfg_tvalid = 1'b0;
        bus.s_axis_cfg_tdata  = 2'd3;   // must be ignored from here on
        if (expect_frame) begin
            check("first_beat_valid", 32'(bus.m_axis_out_tvalid), 32'd1);
            check("first_beat_user", 32'(bus.m_axis_out_tuser), 32'd1);
        end
    endtask

    task automatic wait_frame(input string name);
        int b;
        b = 0;
        while (q.size() != 0 && b < 5000) begin
            @(posedge clk); #1;
            b++;
        end
        check({name, "_frame_complete"}, 32'(q.size()), 32'd0);
        check({name, "_tvalid_low_after"}, 32'(bus.m_axis_out_tvalid), 32'd0);
        check({name, "_cfg_ready_after"}, 32'(bus.s_axis_cfg_tready), 32'd1);
    endtask

    initial begin
        int base;
        int b;
        tests = 0; fails = 0; accepted = 0; bp_en = 1'b0;
        x_ref[0] = 0; x_ref[1] = 1; x_ref[2] = 1; x_ref[3] = 0;
        x_ref[4] = 1; x_ref[5] = 1; x_ref[6] = 1;
        for (int i = 0; i < 120; i++) x_ref[i+7] = x_ref[i+4] ^ x_ref[i];

        bus.s_axis_cfg_tdata  = 2'd0;
        bus.s_axis_cfg_tvalid = 1'b0;
        bus.m_axis_out_tready = 1'b1;
        reset_ni = 1'b0;
        #2;
        check("rst_tvalid", 32'(bus.m_axis_out_tvalid), 32'd0);
        check("rst_tdata", bus.m_axis_out_tdata, 32'd0);
        check("rst_cfg_ready", 32'(bus.s_axis_cfg_tready), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        @(posedge clk); #1;
        check("cfg_ready_first_edge", 32'(bus.s_axis_cfg_tready), 32'd1);

        // Nominal frame and the other two sequences
        send_cfg(2'd0, 1'b1); wait_frame("nid0");
        send_cfg(2'd1, 1'b1); wait_frame("nid1");
        send_cfg(2'd2, 1'b1); wait_frame("nid2");

        // Backpressure
        bp_en = 1'b1;
        send_cfg(2'd0, 1'b1); wait_frame("bp");
        bp_en = 1'b0;

        // Invalid request
        send_cfg(2'd3, 1'b0);
        check("err_pulse_high", 32'(cfg_err), 32'd1);
        check("err_no_beat", 32'(bus.m_axis_out_tvalid), 32'd0);
        @(posedge clk); #1;
        check("err_pulse_low", 32'(cfg_err), 32'd0);
        check("err_no_beat_later", 32'(bus.m_axis_out_tvalid), 32'd0);
        send_cfg(2'd0, 1'b1); wait_frame("after_err");

        // Reset at beat 100 of a frame
        base = accepted;
        send_cfg(2'd0, 1'b1);
        b = 0;
        while (accepted < base + 100 && b < 1000) begin
            @(posedge clk); #1;
            b++;
        end
        check("reached_beat_100", 32'(accepted - base), 32'd100);
        #1 reset_ni = 1'b0;
        #1;
        check("async_rst_tvalid", 32'(bus.m_axis_out_tvalid), 32'd0);
        check("async_rst_cfg_ready", 32'(bus.s_axis_cfg_tready), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        @(posedge clk); #1;
        check("cfg_ready_after_rst", 32'(bus.s_axis_cfg_tready), 32'd1);
        check("no_resume_after_rst", 32'(bus.m_axis_out_tvalid), 32'd0);
        send_cfg(2'd0, 1'b1); wait_frame("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule : tb_pss_tx_gen
`default_nettype wire
